// File: rtl/dmem_arb_pkg.sv
// Shared types for the LSQ-to-dcache request arbiter.
// Holds the FSM state and round-robin grant encodings.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE
  } state_t;

  typedef enum logic {
    GRANT_LOAD,
    GRANT_STORE
  } grant_t;

  function automatic logic [31:0] word_addr(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin select between load and store requesters.
// Ports: clk, rst, en (arbiter may grant), req_ld/req_st in, gnt_ld/gnt_st out.
module rr_arb2
  import dmem_arb_pkg::*;
#(
  parameter bit FIRST_GRANT_STORE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_ld,
  input  logic req_st,
  output logic gnt_ld,
  output logic gnt_st
);

  grant_t last_q;
  grant_t last_d;

  // A grant is a transfer (ready follows valid), so last
  // winner updates on any grant.
  always_comb begin
    gnt_ld = en && req_ld
          && (!req_st || last_q == GRANT_STORE);
    gnt_st = en && req_st
          && (!req_ld || last_q == GRANT_LOAD);
    last_d = last_q;
    if (gnt_ld) begin
      last_d = GRANT_LOAD;
    end else if (gnt_st) begin
      last_d = GRANT_STORE;
    end
  end

  // Seeded with the loser so the first tie goes to the
  // configured side.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= FIRST_GRANT_STORE ? GRANT_LOAD
                                  : GRANT_STORE;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_ldst_arbiter.sv
// Merges ldq and stq dmem requests onto one blocking dcache port.
// Ports: ldq_*/stq_* valid-ready requests and resp pulses; dmem_* cache side.
module dmem_ldst_arbiter
  import dmem_arb_pkg::*;
#(
  parameter bit FIRST_GRANT_STORE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ldq_valid,
  output logic        ldq_ready,
  input  logic [31:0] ldq_addr,
  input  logic [3:0]  ldq_rmask,
  output logic        ldq_resp,
  output logic [31:0] ldq_rdata,
  input  logic        stq_valid,
  output logic        stq_ready,
  input  logic [31:0] stq_addr,
  input  logic [3:0]  stq_wmask,
  input  logic [31:0] stq_wdata,
  output logic        stq_resp,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  rmask_q, rmask_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic        gnt_ld, gnt_st;
  logic        unused_lo;

  assign unused_lo = ^{ldq_addr[1:0], stq_addr[1:0]};

  rr_arb2 #(
    .FIRST_GRANT_STORE(FIRST_GRANT_STORE)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == IDLE),
    .req_ld (ldq_valid),
    .req_st (stq_valid),
    .gnt_ld (gnt_ld),
    .gnt_st (gnt_st)
  );

  assign ldq_ready  = gnt_ld;
  assign stq_ready  = gnt_st;
  assign dmem_addr  = addr_q;
  assign dmem_rmask = rmask_q;
  assign dmem_wmask = wmask_q;
  assign dmem_wdata = wdata_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rmask_d   = rmask_q;
    wmask_d   = wmask_q;
    wdata_d   = wdata_q;
    ldq_resp  = 1'b0;
    stq_resp  = 1'b0;
    ldq_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_ld) begin
          state_d = LOAD;
          addr_d  = word_addr(ldq_addr);
          rmask_d = ldq_rmask;
          wmask_d = '0;
        end else if (gnt_st) begin
          state_d = STORE;
          addr_d  = word_addr(stq_addr);
          wmask_d = stq_wmask;
          wdata_d = stq_wdata;
          rmask_d = '0;
        end
      end
      LOAD: begin
        // Response forwarded combinationally in the
        // cache's resp cycle.
        if (dmem_resp) begin
          ldq_resp  = 1'b1;
          ldq_rdata = dmem_rdata;
          state_d   = IDLE;
          rmask_d   = '0;
        end
      end
      STORE: begin
        if (dmem_resp) begin
          stq_resp = 1'b1;
          state_d  = IDLE;
          wmask_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        rmask_d = '0;
        wmask_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
    end
  end

  a_ld_mask: assert property (
    @(posedge clk) disable iff (rst)
    ldq_valid |-> ldq_rmask != 4'b0
  );

  a_st_mask: assert property (
    @(posedge clk) disable iff (rst)
    stq_valid |-> stq_wmask != 4'b0
  );

  a_one_ready: assert property (
    @(posedge clk) disable iff (rst)
    !(ldq_ready && stq_ready)
  );

endmodule

// File: tb/tb_dmem_ldst_arbiter.sv
// Self-checking bench for dmem_ldst_arbiter.
// Directed scenarios followed by random traffic against a reference model.
module tb_dmem_ldst_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ldq_valid, ldq_ready, ldq_resp;
  logic [31:0] ldq_addr, ldq_rdata;
  logic [3:0]  ldq_rmask;
  logic        stq_valid, stq_ready, stq_resp;
  logic [31:0] stq_addr, stq_wdata;
  logic [3:0]  stq_wmask;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic        dmem_resp;

  dmem_ldst_arbiter #(.FIRST_GRANT_STORE(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .ldq_valid  (ldq_valid),
    .ldq_ready  (ldq_ready),
    .ldq_addr   (ldq_addr),
    .ldq_rmask  (ldq_rmask),
    .ldq_resp   (ldq_resp),
    .ldq_rdata  (ldq_rdata),
    .stq_valid  (stq_valid),
    .stq_ready  (stq_ready),
    .stq_addr   (stq_addr),
    .stq_wmask  (stq_wmask),
    .stq_wdata  (stq_wdata),
    .stq_resp   (stq_resp),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: who owns the cache (0 none, 1 load, 2 store),
  // who won the last grant (0 load, 1 store), and the request
  // the cache is currently being shown.
  int          m_busy;
  int          m_last;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_rmask, m_wmask;
  byte         grants[$];
  logic        e_ldr, e_str, e_lresp, e_sresp;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%08h expected=%08h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_last  = 1;
    m_addr  = 0;
    m_wdata = 0;
    m_rmask = 0;
    m_wmask = 0;
  endtask

  // One clock: check at negedge, advance model at posedge.
  task automatic cyc();
    @(negedge clk);
    e_ldr = (m_busy == 0) && ldq_valid
         && (!stq_valid || m_last == 1);
    e_str = (m_busy == 0) && stq_valid
         && (!ldq_valid || m_last == 0);
    e_lresp = (m_busy == 1) && dmem_resp;
    e_sresp = (m_busy == 2) && dmem_resp;
    chk("ldq_ready", ldq_ready, e_ldr);
    chk("stq_ready", stq_ready, e_str);
    chk("ldq_resp", ldq_resp, e_lresp);
    chk("stq_resp", stq_resp, e_sresp);
    if (e_lresp) chk("ldq_rdata", ldq_rdata, dmem_rdata);
    chk("dmem_addr", dmem_addr, m_addr);
    chk("dmem_rmask", dmem_rmask, m_rmask);
    chk("dmem_wmask", dmem_wmask, m_wmask);
    chk("dmem_wdata", dmem_wdata, m_wdata);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (e_ldr) begin
      m_busy  = 1;
      m_last  = 0;
      m_addr  = ldq_addr & 32'hFFFF_FFFC;
      m_rmask = ldq_rmask;
      m_wmask = 0;
      grants.push_back("L");
    end else if (e_str) begin
      m_busy  = 2;
      m_last  = 1;
      m_addr  = stq_addr & 32'hFFFF_FFFC;
      m_wmask = stq_wmask;
      m_wdata = stq_wdata;
      m_rmask = 0;
      grants.push_back("S");
    end else if (e_lresp || e_sresp) begin
      m_busy  = 0;
      m_rmask = 0;
      m_wmask = 0;
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=done");
    $fatal(1);
  end

  initial begin
    string order;
    rst = 1'b1;
    ldq_valid = 0; ldq_addr = 0; ldq_rmask = 0;
    stq_valid = 0; stq_addr = 0; stq_wmask = 0;
    stq_wdata = 0; dmem_rdata = 0; dmem_resp = 0;
    model_reset();
    @(posedge clk); #1;
    cyc(); cyc();
    chk("rst_rmask", dmem_rmask, 0);
    chk("rst_wmask", dmem_wmask, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_ldq_rdata", ldq_rdata, 0);
    rst = 1'b0;

    // single load
    ldq_valid = 1; ldq_addr = 32'h1000_0006;
    ldq_rmask = 4'b1100;
    cyc();
    ldq_valid = 0; ldq_rmask = 0;
    chk("ld_addr", dmem_addr, 32'h1000_0004);
    chk("ld_rmask", dmem_rmask, 4'b1100);
    cyc(); cyc(); cyc();
    chk("ld_rmask_held", dmem_rmask, 4'b1100);
    dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_resp", ldq_resp, 1);
    chk("ld_rdata", ldq_rdata, 32'hDEAD_BEEF);
    cyc();
    dmem_resp = 0;
    chk("ld_rmask_clr", dmem_rmask, 0);
    cyc();

    // single store
    stq_valid = 1; stq_addr = 32'h2000_0000;
    stq_wmask = 4'b1111; stq_wdata = 32'h1234_5678;
    cyc();
    stq_valid = 0; stq_wmask = 0; stq_wdata = 0;
    chk("st_wmask", dmem_wmask, 4'b1111);
    chk("st_wdata", dmem_wdata, 32'h1234_5678);
    cyc(); cyc();
    dmem_resp = 1;
    #1;
    chk("st_resp", stq_resp, 1);
    chk("st_no_ldresp", ldq_resp, 0);
    cyc();
    dmem_resp = 0;
    #1;
    chk("st_resp_pulse", stq_resp, 0);
    cyc();

    // contention from reset
    rst = 1; cyc(); rst = 0;
    grants.delete();
    ldq_valid = 1; ldq_addr = 32'h0000_0040;
    ldq_rmask = 4'b0001;
    stq_valid = 1; stq_addr = 32'h0000_0080;
    stq_wmask = 4'b0010; stq_wdata = 32'hCAFE_0000;
    for (int k = 0; k < 40 && grants.size() < 4; k++) begin
      dmem_resp = (m_busy != 0);
      cyc();
    end
    ldq_valid = 0; stq_valid = 0;
    dmem_resp = 1; cyc(); dmem_resp = 0; cyc();
    chk("grant_cnt", grants.size(), 4);
    order = "LSLS";
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size())
        chk("grant_order", grants[i], order[i]);
    end

    // busy hold
    stq_valid = 1; stq_wmask = 4'b1000;
    stq_addr = 32'h3000_0010;
    cyc();
    stq_valid = 0;
    ldq_valid = 1; ldq_addr = 32'h3000_0008;
    ldq_rmask = 4'b0011;
    #1;
    chk("hold_ready_busy", ldq_ready, 0);
    cyc(); cyc();
    dmem_resp = 1; cyc(); dmem_resp = 0;
    #1;
    chk("hold_ready_r1", ldq_ready, 1);
    cyc();
    ldq_valid = 0;
    chk("hold_rmask_r2", dmem_rmask, 4'b0011);
    dmem_resp = 1; cyc(); dmem_resp = 0; cyc();

    // stray response in idle
    dmem_resp = 1; dmem_rdata = 32'h5555_AAAA;
    #1;
    chk("stray_ldq_resp", ldq_resp, 0);
    chk("stray_stq_resp", stq_resp, 0);
    cyc();
    dmem_resp = 0;
    ldq_valid = 1;
    #1;
    chk("stray_idle", ldq_ready, 1);
    ldq_valid = 0;
    cyc();

    // reset mid-load: last winner is load, reset reseeds it
    ldq_valid = 1; ldq_addr = 32'h4000_0000;
    ldq_rmask = 4'b0100;
    cyc();
    ldq_valid = 0;
    cyc();
    rst = 1; cyc(); rst = 0;
    chk("rst_mid_rmask", dmem_rmask, 0);
    dmem_resp = 1;
    #1;
    chk("rst_mid_no_resp", ldq_resp, 0);
    cyc();
    dmem_resp = 0;
    grants.delete();
    ldq_valid = 1; stq_valid = 1;
    stq_wmask = 4'b0001;
    cyc();
    ldq_valid = 0; stq_valid = 0;
    chk("rst_tie", grants.size() > 0 ? grants[0] : 8'h00,
        8'h4C);
    dmem_resp = 1; cyc(); dmem_resp = 0; cyc();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      rst        = ($urandom_range(0, 80) == 0);
      ldq_valid  = $urandom_range(0, 1);
      stq_valid  = $urandom_range(0, 1);
      ldq_addr   = $urandom;
      stq_addr   = $urandom;
      ldq_rmask  = 4'($urandom_range(1, 15));
      stq_wmask  = 4'($urandom_range(1, 15));
      stq_wdata  = $urandom;
      dmem_rdata = $urandom;
      dmem_resp  = ($urandom_range(0, 2) == 0);
      cyc();
    end
    rst = 0; ldq_valid = 0; stq_valid = 0;
    for (int k = 0; k < 4; k++) begin
      dmem_resp = (m_busy != 0);
      cyc();
    end
    dmem_resp = 0;
    chk("final_idle_rmask", dmem_rmask, 0);
    chk("final_idle_wmask", dmem_wmask, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_ldst_arbiter.md
Name: dmem_ldst_arbiter

Overview:
Merges the load queue's dmem request channel and the store queue's dmem request channel onto the single blocking data-cache port.
- Sits between the LSQ (ldq/stq) and the data cache.
- One request is in flight at a time.
- Grants are round-robin when both queues request in the same cycle.
- The response is routed back to the queue that owns the in-flight request.

Parameters:
FIRST_GRANT_STORE, 0, tie-break winner for the first contended grant after reset (0 = load, 1 = store)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ldq_valid  in  1  load request valid
ldq_ready  out  1  arbiter accepts load this cycle
ldq_addr  in  32  load byte address
ldq_rmask  in  4  load byte mask, nonzero when valid
ldq_resp  out  1  load data returned, one-cycle pulse
ldq_rdata  out  32  load data, valid with ldq_resp
stq_valid  in  1  store request valid
stq_ready  out  1  arbiter accepts store this cycle
stq_addr  in  32  store byte address
stq_wmask  in  4  store byte mask, nonzero when valid
stq_wdata  in  32  store data, lane-aligned
stq_resp  out  1  store complete, one-cycle pulse
dmem_addr  out  32  cache word address
dmem_rmask  out  4  cache read mask
dmem_wmask  out  4  cache write mask
dmem_wdata  out  32  cache write data
dmem_rdata  in  32  cache read data
dmem_resp  in  1  cache done, one-cycle pulse

Behaviour:
- Clocking and reset: single clock, clk. Reset rst is synchronous and active-high.
- State machine: IDLE, LOAD, STORE.
- Reset values:
  - state = IDLE; all dmem_* = 0.
  - ldq_resp = stq_resp = 0; ldq_rdata = 0.
  - last_grant = ~FIRST_GRANT_STORE, so the first tie goes to FIRST_GRANT_STORE.
- Handshake:
  - Transfer occurs when valid && ready.
  - Requesters must not make valid depend on ready.
  - ready may depend on both valids.
- Ready (IDLE only; both readys are 0 in LOAD and STORE):
  - ldq_ready = ldq_valid && (!stq_valid || last_grant == store).
  - stq_ready = stq_valid && (!ldq_valid || last_grant == load).
  - The two readys are never both 1.
- Grant:
  - On a transfer, register the request and update last_grant.
  - Next state is LOAD or STORE.
- Registered dmem request:
  - dmem_addr = {addr[31:2], 2'b00}.
  - LOAD: dmem_rmask = ldq_rmask, dmem_wmask = 0.
  - STORE: dmem_wmask = stq_wmask, dmem_wdata = stq_wdata, dmem_rmask = 0.
  - All dmem_* outputs are driven from flops and held stable from the cycle after acceptance through the dmem_resp cycle inclusive.
  - Masks return to 0 in IDLE. dmem_wdata and dmem_addr may hold their last value.
- Response:
  - In LOAD with dmem_resp: ldq_resp = 1 and ldq_rdata = dmem_rdata in the same cycle (combinational); next state IDLE.
  - In STORE with dmem_resp: stq_resp = 1; next state IDLE.
- Latency:
  - Accept at cycle T; masks visible at T+1.
  - Resp forwarded in the same cycle R that the cache asserts dmem_resp.
  - Next accept possible at R+1, next masks at R+2.
  - Minimum 1 idle cycle between back-to-back cache requests.
- Boundary conditions:
  - dmem_resp in IDLE is ignored; never forwarded.
  - A requester valid held during a busy period stays pending; its ready stays 0 until IDLE.
  - Continuous contention alternates load and store each grant; no starvation.
  - rst during LOAD/STORE aborts the in-flight request. Masks are 0 the cycle after reset; no resp is forwarded for it.
  - A zero mask with valid is a protocol error; flag with an assertion, no RTL handling.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum state_t {IDLE, LOAD, STORE}.
  - typedef enum grant_t {GRANT_LOAD, GRANT_STORE}.
- Sub-module rr_arb2 (2-input round-robin select with last_grant flop and update-on-accept).
- The FSM and request registers stay in the top module.

Test Plan:
- Single load: ldq addr=0x1000_0006, rmask=4'b1100 -> dmem_addr=0x1000_0004, rmask=1100 at T+1 and held. Cache resp with rdata=0xDEAD_BEEF after 3 cycles -> ldq_resp pulse, rdata=0xDEAD_BEEF; masks 0 next cycle.
- Single store: addr=0x2000_0000, wmask=1111, wdata=0x1234_5678 -> dmem_wmask=1111, wdata held until resp -> stq_resp single pulse, ldq_resp stays 0.
- Contention from reset (FIRST_GRANT_STORE=0): both valid continuously for 4 grants -> grant order L,S,L,S. Each resp is routed only to its owner.
- Busy hold: store accepted, load raises valid during STORE -> ldq_ready=0 until IDLE; load accepted at R+1, dmem_rmask at R+2.
- Stray resp: dmem_resp pulsed in IDLE -> no ldq_resp/stq_resp, state stays IDLE.
- Reset mid-load: rst in LOAD before resp, then dmem_resp -> masks 0 after reset, no ldq_resp; the next contended grant follows the reset tie-break.
